add_seq_ctrl: RTL

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/add_seq_ctrl.sv
// Byte-serial adder controller: one shared 8-bit adder walks the operands one
// slice per clock, rippling the carry through a register between slices.
module add_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   x,
    input  logic [8*NBYTES-1:0]   y,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   z,
    output logic                  cout,
    output logic [1:0]            dbg_state
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    x_lat;
    logic [W-1:0]    y_lat;
    logic [KW-1:0]   k;
    logic            carry;
    logic [7:0]      xs;
    logic [7:0]      ys;
    logic [8:0]      sum;

    assign dbg_state = state;

    // Slice select feeding the single shared 8-bit adder.
    always_comb begin
        xs = '0;
        ys = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (k == KW'(i)) begin
                xs = x_lat[8*i +: 8];
                ys = y_lat[8*i +: 8];
            end
        end
        sum = {1'b0, xs} + {1'b0, ys} + {8'd0, carry};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            x_lat <= '0;
            y_lat <= '0;
            k     <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            z     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_lat <= x;
                        y_lat <= y;
                        carry <= cin;
                        z     <= '0;
                        cout  <= 1'b0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (k == KW'(i)) begin
                            z[8*i +: 8] <= sum[7:0];
                        end
                    end
                    carry <= sum[8];
                    if (k == KLAST) begin
                        cout  <= sum[8];
                        k     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
